timer_set_ctrl: RTL and testbench

Time-setting controller for the BCD seconds/minutes/hours timer driving HEX0–HEX5. It sequences the timer between counting and user editing. Two debounced push-buttons step through hour/minute/second edit fields and increment the selected field with BCD wrap. The block blinks the field under edit and issues a one-cycle load pulse that writes the edited time back into the timer counters.

---
 rtl/timer_set_ctrl.sv | 163 ++++++++++++++++
 tb/tb_timer_set_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/timer_set_ctrl.sv
// Time-setting controller for the BCD HH:MM:SS timer: sequences RUN and the
// three edit fields, edits a shadow copy of the time, blinks the field under edit.
module timer_set_ctrl #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BLINK_HALF = CLOCK_FREQ / 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mode,
    input  logic       i_inc,
    input  logic [7:0] i_sec,
    input  logic [7:0] i_min,
    input  logic [7:0] i_hour,
    output logic       o_run,
    output logic       o_load,
    output logic [7:0] o_sec,
    output logic [7:0] o_min,
    output logic [7:0] o_hour,
    output logic [5:0] o_blank,
    output logic [1:0] o_mode
);

    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SET_H = 2'd1;
    localparam logic [1:0] ST_SET_M = 2'd2;
    localparam logic [1:0] ST_SET_S = 2'd3;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX   = 8'h59;

    logic             modePrev_q, incPrev_q;
    logic [1:0]       state_q, state_d;
    logic             run_q, run_d;
    logic             load_q, load_d;
    logic [7:0]       sec_q, sec_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       hour_q, hour_d;
    logic [5:0]       blank_q, blank_d;
    logic [CNT_W-1:0] blinkCnt_q, blinkCnt_d;
    logic             phase_q, phase_d;

    logic modeRise, incRise, blinkClr;

    // Anything at or past the field's top value, or with a non-decimal units
    // digit, rolls over to 00 so a garbage capture can always be recovered.
    function automatic logic [7:0] bcdInc(input logic [7:0] val, input logic [7:0] maxVal);
        logic [7:0] res;
        if (val >= maxVal || val[3:0] > 4'd9) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'h0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    assign modeRise = i_mode & ~modePrev_q;
    assign incRise  = i_inc & ~incPrev_q;

    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        load_d   = 1'b0;
        blinkClr = 1'b0;

        if (modeRise) begin
            blinkClr = 1'b1;
            case (state_q)
                ST_RUN: begin
                    state_d = ST_SET_H;
                    hour_d  = i_hour;
                    min_d   = i_min;
                    sec_d   = i_sec;
                end
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = ST_SET_S;
                ST_SET_S: begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end
                default:  state_d = ST_RUN;
            endcase
        end else if (incRise && state_q != ST_RUN) begin
            blinkClr = 1'b1;
            case (state_q)
                ST_SET_H: hour_d = bcdInc(hour_q, HOUR_MAX);
                ST_SET_M: min_d  = bcdInc(min_q, MS_MAX);
                ST_SET_S: sec_d  = bcdInc(sec_q, MS_MAX);
                default:  sec_d  = sec_q;
            endcase
        end
    end

    // Clearing on every edit restarts the blink in the visible phase.
    always_comb begin
        blinkCnt_d = blinkCnt_q;
        phase_d    = phase_q;
        if (blinkClr) begin
            blinkCnt_d = '0;
            phase_d    = 1'b0;
        end else if (blinkCnt_q == CNT_LAST) begin
            blinkCnt_d = '0;
            phase_d    = ~phase_q;
        end else begin
            blinkCnt_d = blinkCnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        blank_d = 6'b000000;
        case (state_d)
            ST_SET_H: blank_d[5:4] = {2{phase_d}};
            ST_SET_M: blank_d[3:2] = {2{phase_d}};
            ST_SET_S: blank_d[1:0] = {2{phase_d}};
            default:  blank_d = 6'b000000;
        endcase
        run_d = (state_d == ST_RUN);
    end

    // Prev registers reset high so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            modePrev_q <= 1'b1;
            incPrev_q  <= 1'b1;
            state_q    <= ST_RUN;
            run_q      <= 1'b1;
            load_q     <= 1'b0;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            hour_q     <= 8'h00;
            blank_q    <= 6'b000000;
            blinkCnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            modePrev_q <= i_mode;
            incPrev_q  <= i_inc;
            state_q    <= state_d;
            run_q      <= run_d;
            load_q     <= load_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            blank_q    <= blank_d;
            blinkCnt_q <= blinkCnt_d;
            phase_q    <= phase_d;
        end
    end

    assign o_mode  = state_q;
    assign o_run   = run_q;
    assign o_load  = load_q;
    assign o_sec   = sec_q;
    assign o_min   = min_q;
    assign o_hour  = hour_q;
    assign o_blank = blank_q;

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Bench for timer_set_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a decimal-arithmetic model of the controller.
module tb_timer_set_ctrl;

    localparam int HALF = 2;

    logic       clk = 1'b0;
    logic       rst, i_mode, i_inc;
    logic [7:0] i_sec, i_min, i_hour;
    logic       o_run, o_load;
    logic [7:0] o_sec, o_min, o_hour;
    logic [5:0] o_blank;
    logic [1:0] o_mode;

    int total = 0;
    int bad   = 0;
    int loadSeen = 0;

    int mMode, mHour, mMin, mSec, mSince;
    bit mLoad, mPrevMode, mPrevInc;

    always #5 clk = ~clk;

    timer_set_ctrl #(.CLOCK_FREQ(8)) dut (
        .clk(clk), .rst(rst), .i_mode(i_mode), .i_inc(i_inc),
        .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .o_run(o_run), .o_load(o_load), .o_sec(o_sec), .o_min(o_min),
        .o_hour(o_hour), .o_blank(o_blank), .o_mode(o_mode)
    );

    function automatic logic [7:0] toBcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int fromBcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int incField(input int v, input int lim);
        return (v >= lim) ? 0 : v + 1;
    endfunction

    function automatic logic [5:0] expBlank();
        if (mMode == 0 || ((mSince / HALF) % 2) == 0) return 6'b000000;
        if (mMode == 1) return 6'b110000;
        if (mMode == 2) return 6'b001100;
        return 6'b000011;
    endfunction

    // Field limits are expressed as the largest legal decimal value.
    task automatic modelStep();
        bit mr, ir;
        if (rst) begin
            mMode = 0; mHour = 0; mMin = 0; mSec = 0;
            mLoad = 0; mSince = 0; mPrevMode = 1; mPrevInc = 1;
        end else begin
            mr = i_mode && !mPrevMode;
            ir = i_inc && !mPrevInc;
            mLoad = 0;
            if (mr) begin
                if (mMode == 0) begin
                    mHour = fromBcd(i_hour); mMin = fromBcd(i_min); mSec = fromBcd(i_sec);
                end
                if (mMode == 3) mLoad = 1;
                mMode  = (mMode + 1) % 4;
                mSince = 0;
            end else if (ir && mMode != 0) begin
                if (mMode == 1) mHour = incField(mHour, 23);
                else if (mMode == 2) mMin = incField(mMin, 59);
                else mSec = incField(mSec, 59);
                mSince = 0;
            end else begin
                mSince++;
            end
            mPrevMode = i_mode;
            mPrevInc  = i_inc;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("o_mode",  32'(o_mode),  32'(mMode));
        checkOutput("o_run",   32'(o_run),   32'(mMode == 0));
        checkOutput("o_load",  32'(o_load),  32'(mLoad));
        checkOutput("o_hour",  32'(o_hour),  32'(toBcd(mHour)));
        checkOutput("o_min",   32'(o_min),   32'(toBcd(mMin)));
        checkOutput("o_sec",   32'(o_sec),   32'(toBcd(mSec)));
        checkOutput("o_blank", 32'(o_blank), 32'(expBlank()));
        if (o_load === 1'b1) loadSeen++;
    endtask

    task automatic applyStimulus(input bit m, input bit inc, input bit r);
        i_mode = m;
        i_inc  = inc;
        rst    = r;
        modelStep();
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0);
    endtask

    task automatic pressMode();
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0);
        idle(3);
    endtask

    task automatic pressInc();
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0);
        idle(2);
    endtask

    task automatic setTime(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        i_hour = h; i_min = m; i_sec = s;
    endtask

    initial begin
        bit rm, ri;
        setTime(8'h00, 8'h00, 8'h00);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        idle(100);

        // Capture and load-back round trip
        setTime(8'h12, 8'h34, 8'h56);
        pressMode();
        setTime(8'h00, 8'h00, 8'h00);
        loadSeen = 0;
        for (int k = 0; k < 3; k++) pressMode();
        checkOutput("load_count", 32'(loadSeen), 32'd1);

        // Wrap behaviour in each field, with blink observation in SET_M
        setTime(8'h22, 8'h58, 8'h09);
        pressMode();
        for (int k = 0; k < 3; k++) pressInc();
        pressMode();
        idle(9);
        for (int k = 0; k < 2; k++) pressInc();
        pressMode();
        idle(7);
        pressInc();
        pressMode();

        // Simultaneous mode and inc rise in SET_H: mode wins
        setTime(8'h05, 8'h06, 8'h07);
        pressMode();
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        idle(3);
        pressMode();
        pressMode();

        // Buttons held through reset release must not fire
        pressMode();
        applyStimulus(1, 1, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        idle(3);

        // Reset in the middle of an edit
        setTime(8'h11, 8'h22, 8'h33);
        pressMode(); pressMode(); pressMode();
        loadSeen = 0;
        applyStimulus(0, 0, 1);
        idle(6);
        checkOutput("no_load_after_rst", 32'(loadSeen), 32'd0);

        // Random traffic
        rm = 0; ri = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rm = ~rm;
            if ($urandom_range(0, 3) == 0) ri = ~ri;
            setTime(8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9)),
                    8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9)),
                    8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9)));
            applyStimulus(rm, ri, $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
